// File: rtl/inst_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inst_buffer                                                     |
// | Brief    : Circular instruction queue between fetch (2-wide packages) and  |
// |            decode (2 issue slots). Optional bypass: INST_BUFFER_BYPASS_EN. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module inst_buffer #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic [127:0] inst_package_i,
    input  logic         package_valid_i,
    input  logic         stall_i,
    output logic         full_o,
    output logic         out0_valid_o,
    output logic         out1_valid_o,
    output logic [31:0]  out0_pc_o,
    output logic [31:0]  out1_pc_o,
    output logic [31:0]  out0_inst_o,
    output logic [31:0]  out1_inst_o,
    output logic [1:0]   out0_br_o,
    output logic [1:0]   out1_br_o
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_thr = c_cnt_w'(DEPTH - 2);
    localparam logic [c_cnt_w-1:0] c_cnt_two  = c_cnt_w'(2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  br;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [c_addr_w-1:0]   head_q, head_d;
    logic [c_addr_w-1:0]   tail_q, tail_d;
    logic [c_cnt_w-1:0]    count_q, count_d;

    logic [31:0]           w_pc;
    logic                  w_v0, w_v1;
    entry_t                w_ent0, w_ent1, w_first;
    logic [1:0]            w_enq_n, w_enq_eff, w_deq_n;
    logic                  w_has1, w_has2;
    logic                  w_bypass, w_enq_ok;
    logic [c_addr_w-1:0]   w_head_p1, w_tail_p1;
    entry_t                w_slot0, w_slot1;
    logic                  w_slot0_v, w_slot1_v;
    logic                  w_unused_pkg;

    assign w_pc   = inst_package_i[127:96];
    assign w_v0   = inst_package_i[31];
    assign w_v1   = inst_package_i[30];
    assign w_ent0 = '{pc: w_pc,         inst: inst_package_i[95:64], br: inst_package_i[29:28]};
    assign w_ent1 = '{pc: w_pc + 32'd4, inst: inst_package_i[63:32], br: inst_package_i[27:26]};
    // A lone inst1 goes to the tail so the queue never has holes.
    assign w_first      = w_v0 ? w_ent0 : w_ent1;
    assign w_enq_n      = {1'b0, w_v0} + {1'b0, w_v1};
    assign w_unused_pkg = ^inst_package_i[25:0];

    assign w_has1    = (count_q != '0);
    assign w_has2    = (count_q >= c_cnt_two);
    assign full_o    = (count_q > c_full_thr);
    assign w_head_p1 = head_q + c_addr_w'(1);
    assign w_tail_p1 = tail_q + c_addr_w'(1);

`ifdef INST_BUFFER_BYPASS_EN
    assign w_bypass = (count_q == '0) && package_valid_i && !flush_i && !stall_i && !rst
                      && (w_v0 || w_v1);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_enq_ok  = package_valid_i && !full_o && !flush_i && !rst && !w_bypass;
    assign w_enq_eff = w_enq_ok ? w_enq_n : 2'd0;
    assign w_deq_n   = stall_i ? 2'd0 : ({1'b0, w_has1} + {1'b0, w_has2});

    always_comb begin
        w_slot0   = '0;
        w_slot1   = '0;
        w_slot0_v = 1'b0;
        w_slot1_v = 1'b0;
        if (w_bypass) begin
            w_slot0_v = 1'b1;
            w_slot0   = w_first;
            if (w_v0 && w_v1) begin
                w_slot1_v = 1'b1;
                w_slot1   = w_ent1;
            end
        end else begin
            if (w_has1) begin
                w_slot0_v = 1'b1;
                w_slot0   = mem_q[head_q];
            end
            if (w_has2) begin
                w_slot1_v = 1'b1;
                w_slot1   = mem_q[w_head_p1];
            end
        end
    end

    assign out0_valid_o = w_slot0_v;
    assign out0_pc_o    = w_slot0.pc;
    assign out0_inst_o  = w_slot0.inst;
    assign out0_br_o    = w_slot0.br;
    assign out1_valid_o = w_slot1_v;
    assign out1_pc_o    = w_slot1.pc;
    assign out1_inst_o  = w_slot1.inst;
    assign out1_br_o    = w_slot1.br;

    always_comb begin
        head_d  = head_q + c_addr_w'(w_deq_n);
        tail_d  = tail_q + c_addr_w'(w_enq_eff);
        count_d = count_q + c_cnt_w'(w_enq_eff) - c_cnt_w'(w_deq_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (w_enq_ok && (w_v0 || w_v1)) begin
            mem_q[tail_q] <= w_first;
        end
        if (w_enq_ok && w_v0 && w_v1) begin
            mem_q[w_tail_p1] <= w_ent1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_inst_buffer                                                  |
// | Brief    : Directed vector table plus streaming scoreboard for inst_buffer.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_inst_buffer;

    localparam logic [31:0] B = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic [127:0] inst_package_i;
    logic         package_valid_i;
    logic         stall_i;
    logic         full_o;
    logic         out0_valid_o, out1_valid_o;
    logic [31:0]  out0_pc_o, out1_pc_o, out0_inst_o, out1_inst_o;
    logic [1:0]   out0_br_o, out1_br_o;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .inst_package_i  (inst_package_i),
        .package_valid_i (package_valid_i),
        .stall_i         (stall_i),
        .full_o          (full_o),
        .out0_valid_o    (out0_valid_o),
        .out1_valid_o    (out1_valid_o),
        .out0_pc_o       (out0_pc_o),
        .out1_pc_o       (out1_pc_o),
        .out0_inst_o     (out0_inst_o),
        .out1_inst_o     (out1_inst_o),
        .out0_br_o       (out0_br_o),
        .out1_br_o       (out1_br_o)
    );

    typedef struct {
        logic        rst, flush, pv, stall;
        logic [31:0] pc;
        logic        v0, v1;
        logic        e_full, e0v;
        logic [31:0] e0pc;
        logic        e1v;
        logic [31:0] e1pc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Instruction word is ~pc and {br,pt} is pc[3:2], so every field is checkable.
    function automatic logic [127:0] mk_pkg(input logic [31:0] pc, input logic v0, input logic v1);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        return {pc, ~pc, ~p4, v0, v1, pc[3], pc[2], p4[3], p4[2], 26'h0};
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic pv, input logic st,
                                input logic [31:0] pc, input logic v0, input logic v1,
                                input logic ef, input logic e0v, input logic [31:0] e0pc,
                                input logic e1v, input logic [31:0] e1pc);
        vec_t v;
        v.rst = r; v.flush = f; v.pv = pv; v.stall = st;
        v.pc = pc; v.v0 = v0; v.v1 = v1;
        v.e_full = ef; v.e0v = e0v; v.e0pc = e0pc; v.e1v = e1v; v.e1pc = e1pc;
        return v;
    endfunction

    function automatic vec_t idle(input logic e0v, input logic [31:0] e0pc,
                                  input logic e1v, input logic [31:0] e1pc);
        return mk(0, 0, 0, 0, 32'h0, 0, 0, 0, e0v, e0pc, e1v, e1pc);
    endfunction

    task automatic drive(input logic r, input logic f, input logic pv, input logic st,
                         input logic [31:0] pc, input logic v0, input logic v1);
        rst             = r;
        flush_i         = f;
        package_valid_i = pv;
        stall_i         = st;
        inst_package_i  = mk_pkg(pc, v0, v1);
    endtask

    task automatic check_outs(input string tag, input logic ef,
                              input logic e0v, input logic [31:0] e0pc,
                              input logic e1v, input logic [31:0] e1pc);
        logic [31:0] p0, p1;
        p0 = e0v ? e0pc : 32'h0;
        p1 = e1v ? e1pc : 32'h0;
        chk({tag, ".full"},  {31'b0, full_o},       {31'b0, ef});
        chk({tag, ".o0v"},   {31'b0, out0_valid_o}, {31'b0, e0v});
        chk({tag, ".o0pc"},  out0_pc_o,             p0);
        chk({tag, ".o0ins"}, out0_inst_o,           e0v ? ~e0pc : 32'h0);
        chk({tag, ".o0br"},  {30'b0, out0_br_o},    {30'b0, p0[3:2]});
        chk({tag, ".o1v"},   {31'b0, out1_valid_o}, {31'b0, e1v});
        chk({tag, ".o1pc"},  out1_pc_o,             p1);
        chk({tag, ".o1ins"}, out1_inst_o,           e1v ? ~e1pc : 32'h0);
        chk({tag, ".o1br"},  {30'b0, out1_br_o},    {30'b0, p1[3:2]});
    endtask

    initial begin
        // Reset with a package present: it must be discarded.
        vecs.push_back(mk(1, 0, 1, 0, B + 32'h700, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
`ifdef INST_BUFFER_BYPASS_EN
        vecs.push_back(mk(0, 0, 1, 0, B, 1, 1, 0, 1, B, 1, B + 32'h4));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, B + 32'h100, 1, 1, 0, 1, B + 32'h100, 1, B + 32'h104));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, B + 32'h110, 1, 0, 0, 1, B + 32'h110, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h120, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, B + 32'h120, 1, B + 32'h124));
        vecs.push_back(idle(0, 0, 0, 0));
`else
        vecs.push_back(mk(0, 0, 1, 0, B, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, B, 1, B + 32'h4));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, B + 32'h100, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, B + 32'h100, 1, B + 32'h104));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, B + 32'h110, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, B + 32'h110, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
`endif
        // v0=0, v1=1: single entry at pc+4
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h10, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(idle(1, B + 32'h14, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // Build count=5, then flush with a package and stall present
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h200, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h208, 1, 1, 0, 1, B + 32'h200, 1, B + 32'h204));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h210, 1, 0, 0, 1, B + 32'h200, 1, B + 32'h204));
        vecs.push_back(mk(0, 1, 1, 1, B + 32'h218, 1, 1, 0, 1, B + 32'h200, 1, B + 32'h204));
        vecs.push_back(idle(0, 0, 0, 0));
        // Fill to 8 under stall; 5th package dropped
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h300, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h308, 1, 1, 0, 1, B + 32'h300, 1, B + 32'h304));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h310, 1, 1, 0, 1, B + 32'h300, 1, B + 32'h304));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h318, 1, 1, 0, 1, B + 32'h300, 1, B + 32'h304));
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h320, 1, 1, 1, 1, B + 32'h300, 1, B + 32'h304));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 0, 1, 1, B + 32'h300, 1, B + 32'h304));
        vecs.push_back(idle(1, B + 32'h308, 1, B + 32'h30c));
        vecs.push_back(idle(1, B + 32'h310, 1, B + 32'h314));
        vecs.push_back(idle(1, B + 32'h318, 1, B + 32'h31c));
        vecs.push_back(idle(0, 0, 0, 0));
        // Reset mid-operation (with flush also high) discards everything
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h400, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, B + 32'h408, 1, 1, 0, 1, B + 32'h400, 1, B + 32'h404));
        vecs.push_back(idle(0, 0, 0, 0));
        // Simultaneous enqueue and dequeue
        vecs.push_back(mk(0, 0, 1, 1, B + 32'h500, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, B + 32'h508, 1, 1, 0, 1, B + 32'h500, 1, B + 32'h504));
        vecs.push_back(idle(1, B + 32'h508, 1, B + 32'h50c));
        vecs.push_back(idle(0, 0, 0, 0));

        drive(1, 0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].pv, vecs[i].stall,
                  vecs[i].pc, vecs[i].v0, vecs[i].v1);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].e_full, vecs[i].e0v, vecs[i].e0pc,
                       vecs[i].e1v, vecs[i].e1pc);
            @(posedge clk);
            #1;
        end

        // Stream 20 packages with alternating stall; issue order must be exact.
        begin
            int nxt;
            int idx;
            int cyc;
            nxt = 0;
            idx = 0;
            cyc = 0;
            while ((idx < 40 || nxt < 20) && cyc < 400) begin
                drive(0, 0, (nxt < 20), (cyc % 2 == 1), B + 32'h600 + 32'(nxt * 8), 1, 1);
                @(negedge clk);
                if (!stall_i) begin
                    if (out0_valid_o) begin
                        chk($sformatf("s%0d.o0pc", idx), out0_pc_o, B + 32'h600 + 32'(idx * 4));
                        idx++;
                    end
                    if (out1_valid_o) begin
                        chk($sformatf("s%0d.o1pc", idx), out1_pc_o, B + 32'h600 + 32'(idx * 4));
                        idx++;
                    end
                end
                chk("stream.order", {31'b0, out1_valid_o & ~out0_valid_o}, 32'h0);
                if (package_valid_i && !full_o) nxt++;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("stream.issued", 32'(idx), 32'd40);
            chk("stream.pkgs",   32'(nxt), 32'd20);
            drive(0, 0, 0, 0, 32'h0, 0, 0);
            @(negedge clk);
            check_outs("drained", 0, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the number of single-instruction entries (power of two, at least 4).
REQ-002 The module SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high (rst == 1'b1 resets on the next rising edge of clk).
REQ-004 The module SHALL have port flush_i, input, 1 bit: branch-resolve flush, driven by the same signal as the fetch stage's branch_flag_i.
REQ-005 The module SHALL have port inst_package_i, input, 128 bits: fetch package with fields [127:96] pc, [95:64] inst0, [63:32] inst1, [31] v0, [30] v1, [29] br0, [28] pt0, [27] br1, [26] pt1.
REQ-006 The module SHALL have port package_valid_i, input, 1 bit: inst_package_i carries at least one valid instruction.
REQ-007 The module SHALL have port stall_i, input, 1 bit: decode cannot accept instructions this cycle.
REQ-008 The module SHALL have port full_o, output, 1 bit: fewer than 2 free entries; the fetch stage stalls on it.
REQ-009 The module SHALL have ports out0_valid_o/out1_valid_o, outputs, 1 bit each: issue slot holds a valid instruction.
REQ-010 The module SHALL have ports out0_pc_o/out1_pc_o, outputs, 32 bits each: PC of the slot's instruction.
REQ-011 The module SHALL have ports out0_inst_o/out1_inst_o, outputs, 32 bits each: the slot's instruction word.
REQ-012 The module SHALL have ports out0_br_o/out1_br_o, outputs, 2 bits each: {is_branch, pred_taken} of the slot's instruction.

Function
REQ-013 The module SHALL store entries {pc, inst, is_branch, pred_taken} in a circular buffer with head pointer, tail pointer and count; pointers wrap modulo DEPTH, and count is log2(DEPTH)+1 bits wide.
REQ-014 The module SHALL, on package_valid_i=1 with full_o=0 and flush_i=0, enqueue {pc, inst0, br0, pt0} if v0=1, then {pc+4, inst1, br1, pt1} if v1=1, in program order and without holes (v0=0, v1=1 writes one entry at the tail).
REQ-015 The module SHALL discard a package presented while full_o=1; the fetch stage holds it under stall.
REQ-016 The module SHALL assert full_o combinationally whenever count > DEPTH-2.
REQ-017 The module SHALL drive out0 from the head entry when count>=1 and out1 from head+1 when count>=2; outputs are combinational from storage and an invalid slot drives all-zero fields.
REQ-018 The module SHALL, when stall_i=0, pop every valid issue slot (0, 1 or 2 entries); when stall_i=1 it pops nothing.
REQ-019 The module SHALL permit enqueue and dequeue in the same cycle, with next count = count + enq - deq.
REQ-020 The module SHALL give an entry a latency of one cycle: an entry written at edge N appears on the outputs after edge N (without REQ-028).
REQ-021 The module SHALL, on flush_i=1, zero head, tail and count at the edge, ignore any simultaneous enqueue, and drive both valids 0 in the following cycle.
REQ-022 The module SHALL give flush_i priority over stall_i, and rst priority over flush_i.
REQ-023 The module SHALL keep out1_valid_o=1 implying out0_valid_o=1 at all times.

Reset
REQ-024 The module SHALL, on rst=1, clear head, tail and count to 0 at the next rising edge of clk.
REQ-025 The module SHALL hold out0/out1 valid, pc, inst and br at 0 and full_o at 0 after reset.
REQ-026 The module SHALL not require storage contents to be cleared on reset.
REQ-027 The module SHALL treat rst asserted mid-operation identically to flush and discard the package presented in that cycle.

Configuration
REQ-028 The module SHALL, with macro INST_BUFFER_BYPASS_EN defined, drive the outputs directly from inst_package_i in the same cycle when count=0, package_valid_i=1, flush_i=0 and stall_i=0 (the issued instructions are not written); if stall_i=1 the package is enqueued normally.
REQ-029 The module SHALL, with INST_BUFFER_BYPASS_EN undefined, have no bypass path and always apply the one-cycle latency of REQ-020.

Verification
REQ-030 The bench SHALL cover: reset, then package pc=0x80000000, v0=v1=1, stall_i=0 -> next cycle out0 pc 0x80000000, out1 pc 0x80000004, both valid; following cycle both valid 0.
REQ-031 The bench SHALL cover: stall_i=1 while 4 two-instruction packages are presented with DEPTH=8 -> full_o=1 after the 4th edge (count=8), the 5th package is dropped, and head pc is unchanged.
REQ-032 The bench SHALL cover: a package with v0=0, v1=1, pc=0x80000010 -> single entry; out0 pc=0x80000014, out1_valid_o=0.
REQ-033 The bench SHALL cover: count=5 when flush_i=1 coincides with package_valid_i=1 -> count=0 after the edge and both valids 0 next cycle.
REQ-034 The bench SHALL cover: tail wrap, by streaming 20 packages with alternating stall_i -> outputs emerge in exact PC order with no loss or duplication.
REQ-035 The bench SHALL cover: INST_BUFFER_BYPASS_EN defined, empty buffer, package pc=0x80000100 -> out0 pc=0x80000100 valid in the same cycle and count stays 0.
